rhdb_silo: RTL and testbench
============================

Name: rhdb_silo

Overview:
- RH11 data-buffer silo, directly downstream of the RH11 Data Buffer register (RHDB).
- Each completed RHDB write is pushed as one 16-bit word into a DEPTH-entry circular FIFO.
- The FIFO presents words to the drive/transfer engine through a show-ahead valid/acknowledge interface.
- Reports full, empty, occupancy and a sticky overrun error for the RH11 status registers.

Parameters:
- DEPTH, 66, number of 16-bit words held (RH11 silo size); any value 2..127.
- WIDTH, 16, word width; must match the RHDB register width.

Ports:
- clk  input  1  Clock.
- rst  input  1  Reset; asynchronous, active-low. Silo is in reset while rst=0.
- clr  input  1  Synchronous clear (controller clear / RHCS2 CLR); empties silo, clears overrun.
- rhDB  input  WIDTH  Current RHDB register contents.
- rhdbPUSH  input  1  One-cycle strobe, asserted the cycle after an RHDB write, so rhDB already holds the new value.
- drvACK  input  1  Consumer pops the head word this cycle.
- siloDATA  output  WIDTH  Head word; meaningful only while siloVALID=1.
- siloVALID  output  1  Silo not empty.
- siloFULL  output  1  Count equals DEPTH.
- siloEMPTY  output  1  Count equals 0.
- siloCOUNT  output  7  Words currently held, 0..DEPTH.
- siloOVRE  output  1  Sticky overrun: push attempted while full.

Behaviour:
Storage and pointers
- Storage: DEPTH x WIDTH array.
- Write pointer wp, read pointer rp, each 7 bits, range 0..DEPTH-1.
- Pointers wrap from DEPTH-1 to 0. There is no power-of-two wrap; 65 -> 0 when DEPTH=66.

Reset and clear
- While rst=0: wp=0, rp=0, count=0, siloOVRE=0.
  - Outputs: siloVALID=0, siloEMPTY=1, siloFULL=0, siloCOUNT=0.
  - siloDATA=0 because storage array entry 0 reads 0 after reset, or is forced to 0 when empty.
  - Array contents need not be cleared.
- Reset is honoured mid-operation: any in-progress push or pop is discarded.
- clr=1 at a clock edge produces the same state as reset. clr takes priority over push and pop in that cycle.

Push
- On a clock edge with rhdbPUSH=1 and count<DEPTH: mem[wp]<=rhDB, wp advances, count+1.
- On a clock edge with rhdbPUSH=1 and count=DEPTH (no simultaneous pop): word dropped, pointers and count unchanged, siloOVRE<=1.

Pop
- On a clock edge with drvACK=1 and count>0: rp advances, count-1.
- drvACK=1 with count=0 is ignored: no state change, no error.

Simultaneous push and pop
- count=0: push only, count becomes 1. The pushed word is not popped in the same cycle.
- count=DEPTH: both occur, count stays DEPTH, siloOVRE not set.
- 0<count<DEPTH: both occur, count unchanged.

Latency and output
- Show-ahead: siloDATA = mem[rp] (combinational read of the registered pointer).
- A word pushed into an empty silo appears on siloDATA with siloVALID=1 in the cycle after the push edge. Push-to-visible latency is 1 clock.
- After a pop, the next word is visible immediately after that edge.

Status flags
- siloFULL, siloEMPTY and siloVALID are decoded from the registered count; no extra latency.
- siloOVRE stays set until clr or reset.

Test Plan:
- Reset/idle: hold rst=0 then release -> siloEMPTY=1, siloVALID=0, siloFULL=0, siloCOUNT=0, siloOVRE=0.
- Push 16'o123456 into empty silo -> the next cycle shows siloVALID=1 and siloDATA=16'o123456 with siloCOUNT=1. Pulsing drvACK once then gives siloEMPTY=1 and siloCOUNT=0.
- Fill and overrun: push words 1..66 -> siloFULL=1, siloCOUNT=66.
  - 67th push (value 16'o777) -> siloOVRE=1, count stays 66.
  - Pop 66 times -> data 1..66 in order, never 16'o777.
- Wrap-around: push 60 and pop 60, then push 10 (values 100..109), crossing index 65->0 -> pops return 100..109 in order, siloCOUNT returns to 0.
- Simultaneous events: at count=66, assert rhdbPUSH+drvACK together -> count stays 66, siloOVRE stays 0, head advances. At count=0, assert both -> count=1 and the pushed word is at the head.
- Clear/reset mid-operation: with count=5 and siloOVRE=1, assert clr together with rhdbPUSH -> count=0, siloOVRE=0, push discarded. Repeat with rst=0 asynchronously mid-cycle -> outputs return to reset values immediately.

Source files
------------

// File: rtl/rhdb_silo.sv
// ---------------------------------------------------------------------------
// rhdb_silo
//   RH11 data-buffer silo. Every completed RHDB write is pushed as one word
//   into a DEPTH-entry circular FIFO that the drive/transfer engine drains
//   through a show-ahead valid/acknowledge interface. Full, empty, occupancy
//   and a sticky overrun flag feed the RH11 status registers.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   clr        in   synchronous clear (controller clear); empties silo,
//                   clears overrun, wins over push/pop in the same cycle
//   rhDB       in   current RHDB register contents (WIDTH bits)
//   rhdbPUSH   in   one-cycle strobe: push rhDB
//   drvACK     in   consumer pops the head word this cycle
//   siloDATA   out  head word, 0 while empty
//   siloVALID  out  silo holds at least one word
//   siloFULL   out  count equals DEPTH
//   siloEMPTY  out  count equals 0
//   siloCOUNT  out  words held, 0..DEPTH
//   siloOVRE   out  sticky: push attempted while full without a pop
// ---------------------------------------------------------------------------
module rhdb_silo #(
    parameter int DEPTH = 66,   // 2..127
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] rhDB,
    input  logic             rhdbPUSH,
    input  logic             drvACK,
    output logic [WIDTH-1:0] siloDATA,
    output logic             siloVALID,
    output logic             siloFULL,
    output logic             siloEMPTY,
    output logic [6:0]       siloCOUNT,
    output logic             siloOVRE
);

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);
    localparam logic [6:0] LAST_C  = 7'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [6:0] wp_q, wp_d;
    logic [6:0] rp_q, rp_d;
    logic [6:0] count_q, count_d;
    logic       ovre_q, ovre_d;

    logic full, empty;
    logic push_en, pop_en, ovre_set;

    // Next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovre_d  = ovre_q;

        full  = (count_q == DEPTH_C);
        empty = (count_q == 7'd0);

        // A pop from an empty silo is ignored, so a simultaneous push into
        // an empty silo is never popped in the same cycle. When full, a
        // concurrent pop frees the slot the push needs.
        pop_en   = drvACK && !empty;
        push_en  = rhdbPUSH && (!full || drvACK);
        ovre_set = rhdbPUSH && full && !drvACK;

        if (clr) begin
            wp_d    = 7'd0;
            rp_d    = 7'd0;
            count_d = 7'd0;
            ovre_d  = 1'b0;
        end else begin
            // Wrap at DEPTH-1, not at a power of two.
            if (push_en) wp_d = (wp_q == LAST_C) ? 7'd0 : wp_q + 7'd1;
            if (pop_en)  rp_d = (rp_q == LAST_C) ? 7'd0 : rp_q + 7'd1;
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + 7'd1;
                2'b01:   count_d = count_q - 7'd1;
                default: count_d = count_q;
            endcase
            if (ovre_set) ovre_d = 1'b1;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so all registers sample the same pre-edge values.
            wp_q    <= 7'd0;
            rp_q    <= 7'd0;
            count_q <= 7'd0;
            ovre_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovre_q  <= ovre_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are never visible
    // because siloDATA is forced to 0 while the silo is empty.
    always_ff @(posedge clk) begin
        if (push_en && !clr) mem_q[wp_q] <= rhDB;
    end

    // Show-ahead head word, flags decoded straight from the registered count.
    assign siloDATA  = empty ? '0 : mem_q[rp_q];
    assign siloVALID = !empty;
    assign siloFULL  = full;
    assign siloEMPTY = empty;
    assign siloCOUNT = count_q;
    assign siloOVRE  = ovre_q;

endmodule

// File: tb/tb_rhdb_silo.sv
// ---------------------------------------------------------------------------
// tb_rhdb_silo
//   Directed and randomized stimulus for rhdb_silo, compared against a
//   queue-based model of the silo rules (FIFO order, capacity, sticky
//   overrun, clear priority).
// ---------------------------------------------------------------------------
module tb_rhdb_silo;

    localparam int DEPTH = 66;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [WIDTH-1:0] rhDB;
    logic             rhdbPUSH;
    logic             drvACK;
    logic [WIDTH-1:0] siloDATA;
    logic             siloVALID;
    logic             siloFULL;
    logic             siloEMPTY;
    logic [6:0]       siloCOUNT;
    logic             siloOVRE;

    rhdb_silo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .rhDB      (rhDB),
        .rhdbPUSH  (rhdbPUSH),
        .drvACK    (drvACK),
        .siloDATA  (siloDATA),
        .siloVALID (siloVALID),
        .siloFULL  (siloFULL),
        .siloEMPTY (siloEMPTY),
        .siloCOUNT (siloCOUNT),
        .siloOVRE  (siloOVRE)
    );

    always #5 clk = ~clk;

    // Reference model.
    logic [WIDTH-1:0] model_q[$];
    bit               model_ovre;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        model_ovre = 0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"}, 32'(siloCOUNT), 32'(sz));
        check({tag, ".empty"}, 32'(siloEMPTY), 32'(sz == 0));
        check({tag, ".full"},  32'(siloFULL),  32'(sz == DEPTH));
        check({tag, ".valid"}, 32'(siloVALID), 32'(sz != 0));
        check({tag, ".ovre"},  32'(siloOVRE),  32'(model_ovre));
        check({tag, ".data"},  32'(siloDATA),  (sz != 0) ? 32'(model_q[0]) : 32'd0);
    endtask

    // One clock: drive inputs, apply the model rule at the edge, check after.
    task automatic step(input bit push, input bit ack, input logic [WIDTH-1:0] d,
                        input bit c, input string tag);
        bit was_full, was_empty;
        @(negedge clk);
        rhdbPUSH = push;
        drvACK   = ack;
        rhDB     = d;
        clr      = c;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (c) begin
            model_clear();
        end else begin
            if (push && was_full && !ack) model_ovre = 1;
            if (ack && !was_empty) void'(model_q.pop_front());
            if (push && (!was_full || ack)) model_q.push_back(d);
        end
        #1;
        rhdbPUSH = 0;
        drvACK   = 0;
        clr      = 0;
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b0;
        clr      = 1'b0;
        rhDB     = '0;
        rhdbPUSH = 1'b0;
        drvACK   = 1'b0;
        model_clear();

        // Reset / idle.
        repeat (3) @(posedge clk);
        #1 check_all("reset_hold");
        @(negedge clk) rst = 1'b1;
        @(negedge clk) check_all("reset_idle");

        // Single push then pop, one-clock visibility.
        step(1, 0, 16'o123456, 0, "push1");
        check("push1.value", 32'(siloDATA), 32'o123456);
        step(0, 1, 16'h0, 0, "pop1");
        check("pop1.empty", 32'(siloEMPTY), 32'd1);

        // Idle pop on an empty silo is ignored.
        step(0, 1, 16'h0, 0, "pop_empty");

        // Fill 1..66, overrun with 16'o777, drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 16'(i), 0, "fill");
        check("fill.full_flag", 32'(siloFULL), 32'd1);
        check("fill.count66", 32'(siloCOUNT), 32'd66);
        step(1, 0, 16'o777, 0, "overrun");
        check("overrun.ovre", 32'(siloOVRE), 32'd1);
        check("overrun.count", 32'(siloCOUNT), 32'd66);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain.order", 32'(siloDATA), 32'(i));
            step(0, 1, 16'h0, 0, "drain");
        end
        check("drain.ovre_sticky", 32'(siloOVRE), 32'd1);

        // Wrap-around across index 65 -> 0.
        step(0, 0, 16'h0, 1, "clr_wrap");
        for (int i = 0; i < 60; i++) step(1, 0, 16'(i + 500), 0, "wrap_fill");
        for (int i = 0; i < 60; i++) step(0, 1, 16'h0, 0, "wrap_drain");
        for (int i = 0; i < 10; i++) step(1, 0, 16'(100 + i), 0, "wrap_push");
        for (int i = 0; i < 10; i++) begin
            check("wrap.order", 32'(siloDATA), 32'(100 + i));
            step(0, 1, 16'h0, 0, "wrap_pop");
        end
        check("wrap.count0", 32'(siloCOUNT), 32'd0);

        // Simultaneous push+pop at full: no overrun, head advances.
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 16'(i), 0, "sim_fill");
        step(1, 1, 16'hBEEF, 0, "sim_full");
        check("sim_full.count", 32'(siloCOUNT), 32'd66);
        check("sim_full.ovre", 32'(siloOVRE), 32'd0);
        check("sim_full.head", 32'(siloDATA), 32'd2);

        // Simultaneous push+pop at empty: push only.
        step(0, 0, 16'h0, 1, "clr_sim");
        step(1, 1, 16'h1357, 0, "sim_empty");
        check("sim_empty.count", 32'(siloCOUNT), 32'd1);
        check("sim_empty.head", 32'(siloDATA), 32'h1357);

        // Clear with concurrent push at count=5, ovre=1.
        step(0, 0, 16'h0, 1, "clr_pre");
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 16'(i), 0, "clr_fill");
        step(1, 0, 16'o777, 0, "clr_ovr");
        for (int i = 0; i < DEPTH - 5; i++) step(0, 1, 16'h0, 0, "clr_pop");
        check("clr_pre.count5", 32'(siloCOUNT), 32'd5);
        step(1, 0, 16'hAAAA, 1, "clr_push");
        check("clr_push.count", 32'(siloCOUNT), 32'd0);
        check("clr_push.ovre", 32'(siloOVRE), 32'd0);

        // Asynchronous reset mid-cycle with state present.
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 16'(i), 0, "rst_fill");
        step(1, 0, 16'o777, 0, "rst_ovr");
        @(posedge clk);
        #2 rst = 1'b0;
        model_clear();
        #1 check_all("async_rst");
        @(negedge clk) rst = 1'b1;
        @(negedge clk) check_all("async_rst_rel");

        // Randomized phases: push-heavy, balanced, pop-heavy, rare clears.
        for (int ph = 0; ph < 6; ph++) begin
            int push_pct, ack_pct;
            push_pct = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 50 : 20;
            ack_pct  = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 85;
            for (int n = 0; n < 300; n++) begin
                step($urandom_range(99) < push_pct, $urandom_range(99) < ack_pct,
                     16'($urandom), $urandom_range(199) == 0, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
